// File: rtl/idct_transpose_buf.sv
// idct_transpose_buf
// Ping-pong transpose buffer between the row and column 1-D IDCT passes.
// Rows are written whole into one bank; once a bank holds a complete block,
// its columns are gathered combinationally and drained one per handshake.
// The other bank fills at the same time, so both sides can run every cycle.
module idct_transpose_buf #(
   parameter int DATA_W = 8,
   parameter int N      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*DATA_W-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N*DATA_W-1:0] out_data,
   output logic                out_first,
   output logic                out_last,
   output logic [1:0]          blk_cnt
);

   localparam int WW = N * DATA_W;
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);

   // block storage: two banks of N row words
   logic [WW-1:0] mem [2][N];

   logic          wr_bank;
   logic          rd_bank;
   logic [AW-1:0] wr_row;
   logic [AW-1:0] rd_col;
   logic [1:0]    full;

   logic          wr_bank_nxt;
   logic          rd_bank_nxt;
   logic [AW-1:0] wr_row_nxt;
   logic [AW-1:0] rd_col_nxt;
   logic [1:0]    full_nxt;
   logic [1:0]    blk_cnt_nxt;

   logic          wr_fire;
   logic          rd_fire;
   logic          wr_wrap;
   logic          rd_wrap;
   logic [WW-1:0] col_word;

   // ready/valid come straight from the bank flags, never from the inputs
   assign in_ready  = !full[wr_bank];
   assign out_valid = full[rd_bank];

   assign wr_fire = in_valid && in_ready;
   assign rd_fire = out_valid && out_ready;
   assign wr_wrap = wr_fire && (wr_row == IDX_LAST);
   assign rd_wrap = rd_fire && (rd_col == IDX_LAST);

   // row storage write; contents are don't-care until a bank is marked full
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_bank][wr_row] <= in_data;
      end
   end

   // write pointer advance: next row, or flip bank after the last row
   always_comb begin
      wr_bank_nxt = wr_bank;
      wr_row_nxt  = wr_row;
      if (wr_fire) begin
         if (wr_wrap) begin
            wr_row_nxt  = '0;
            wr_bank_nxt = !wr_bank;
         end else begin
            wr_row_nxt = wr_row + AW'(1);
         end
      end
   end

   // read pointer advance: next column, or flip bank after the last column
   always_comb begin
      rd_bank_nxt = rd_bank;
      rd_col_nxt  = rd_col;
      if (rd_fire) begin
         if (rd_wrap) begin
            rd_col_nxt  = '0;
            rd_bank_nxt = !rd_bank;
         end else begin
            rd_col_nxt = rd_col + AW'(1);
         end
      end
   end

   // bank flags: set and clear always target different banks, so both apply
   always_comb begin
      full_nxt = full;
      if (wr_wrap) begin
         full_nxt[wr_bank] = 1'b1;
      end
      if (rd_wrap) begin
         full_nxt[rd_bank] = 1'b0;
      end
      blk_cnt_nxt = {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
   end

   // control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_row  <= '0;
         rd_col  <= '0;
         full    <= 2'b00;
         blk_cnt <= 2'd0;
      end else begin
         wr_bank <= wr_bank_nxt;
         rd_bank <= rd_bank_nxt;
         wr_row  <= wr_row_nxt;
         rd_col  <= rd_col_nxt;
         full    <= full_nxt;
         blk_cnt <= blk_cnt_nxt;
      end
   end

   // column gather: element rd_col of each row, row 0 into the MSB slot
   always_comb begin
      col_word = '0;
      for (int r = 0; r < N; r++) begin
         col_word[WW-1-r*DATA_W -: DATA_W] =
            mem[rd_bank][r][WW-1-int'(rd_col)*DATA_W -: DATA_W];
      end
   end

   // output qualification: nothing stale leaks out when no block is ready
   always_comb begin
      out_data  = out_valid ? col_word : '0;
      out_first = out_valid && (rd_col == '0);
      out_last  = out_valid && (rd_col == IDX_LAST);
   end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Testbench for idct_transpose_buf: block-level reference model (queue of
// completed 8x8 blocks plus a partial block) checked against the DUT.
module tb_idct_transpose_buf;

   localparam int DW = 8;
   localparam int N  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [63:0]   in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [63:0]   out_data;
   logic          out_first;
   logic          out_last;
   logic [1:0]    blk_cnt;

   int checks = 0;
   int failures = 0;

   typedef logic [7:0] blk_t [8][8];
   blk_t done_q[$];
   blk_t cur;
   int   cur_rows = 0;
   int   col_idx = 0;
   int   rows_acc = 0;
   int   cols_acc = 0;
   logic [63:0] acc_cols[$];

   idct_transpose_buf #(.DATA_W(DW), .N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_first(out_first), .out_last(out_last), .blk_cnt(blk_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit exp_ready();
      return done_q.size() < 2;
   endfunction

   function automatic bit exp_valid();
      return done_q.size() > 0;
   endfunction

   function automatic logic [1:0] exp_cnt();
      return 2'(done_q.size());
   endfunction

   function automatic logic [63:0] exp_col();
      logic [63:0] w;
      blk_t b;
      w = '0;
      if (done_q.size() == 0) return w;
      b = done_q[0];
      for (int r = 0; r < 8; r++) w[63-8*r -: 8] = b[r][col_idx];
      return w;
   endfunction

   function automatic logic [63:0] pat_row(int r);
      logic [63:0] w;
      for (int c = 0; c < 8; c++) w[63-8*c -: 8] = {4'(r), 4'(c)};
      return w;
   endfunction

   function automatic logic [63:0] pat_col(int c);
      logic [63:0] w;
      for (int r = 0; r < 8; r++) w[63-8*r -: 8] = {4'(r), 4'(c)};
      return w;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // one clock edge; the model takes the same handshakes the spec defines
   task automatic advance();
      bit wf, rf;
      wf = in_valid && exp_ready();
      rf = out_ready && exp_valid();
      @(posedge clk);
      if (rf) begin
         acc_cols.push_back(exp_col());
         cols_acc++;
         col_idx++;
         if (col_idx == 8) begin
            void'(done_q.pop_front());
            col_idx = 0;
         end
      end
      if (wf) begin
         for (int c = 0; c < 8; c++) cur[cur_rows][c] = in_data[63-8*c -: 8];
         rows_acc++;
         cur_rows++;
         if (cur_rows == 8) begin
            done_q.push_back(cur);
            cur_rows = 0;
         end
      end
      #1;
   endtask

   task automatic model_clear();
      done_q.delete();
      acc_cols.delete();
      cur_rows = 0;
      col_idx = 0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (out_first !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_first_last got=%b%b exp=00", out_first, out_last); end
      checks++; if (blk_cnt !== 2'd0) begin failures++; $display("FAIL reset_blk_cnt got=%0d exp=0", blk_cnt); end
      apply_reset();
   endtask

   task automatic test_transpose();
      int r;
      int c0;
      apply_reset();
      r = 0;
      c0 = cols_acc;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid = (r < 8);
         in_data = (r < 8) ? pat_row(r) : '0;
         out_ready = 1'b1;
         @(negedge clk);
         checks++; if (out_valid !== exp_valid()) begin failures++; $display("FAIL tr_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid()); end
         checks++; if (out_data !== exp_col()) begin failures++; $display("FAIL tr_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_col()); end
         checks++; if (out_first !== (exp_valid() && col_idx == 0)) begin failures++; $display("FAIL tr_first cyc=%0d got=%b", cyc, out_first); end
         checks++; if (out_last !== (exp_valid() && col_idx == 7)) begin failures++; $display("FAIL tr_last cyc=%0d got=%b", cyc, out_last); end
         checks++; if (blk_cnt !== exp_cnt()) begin failures++; $display("FAIL tr_blk_cnt cyc=%0d got=%0d exp=%0d", cyc, blk_cnt, exp_cnt()); end
         if (exp_valid() && col_idx == 3) begin
            checks++; if (out_data !== 64'h03_13_23_33_43_53_63_73) begin failures++; $display("FAIL tr_col3 got=%h exp=0313233343536373", out_data); end
         end
         if (in_valid && exp_ready()) r++;
         advance();
      end
      checks++; if (cols_acc - c0 != 8) begin failures++; $display("FAIL tr_col_count got=%0d exp=8", cols_acc - c0); end
   endtask

   task automatic test_streaming();
      int r0, c0;
      apply_reset();
      r0 = rows_acc;
      c0 = cols_acc;
      for (int cyc = 0; cyc < 45; cyc++) begin
         in_valid = (cyc < 32);
         in_data = rnd64();
         out_ready = 1'b1;
         @(negedge clk);
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL st_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
         checks++; if (out_valid !== (cyc >= 8 && cyc < 40)) begin failures++; $display("FAIL st_valid cyc=%0d got=%b", cyc, out_valid); end
         checks++; if (out_data !== exp_col()) begin failures++; $display("FAIL st_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_col()); end
         advance();
      end
      checks++; if (rows_acc - r0 != 32 || cols_acc - c0 != 32) begin failures++; $display("FAIL st_counts rows=%0d cols=%0d exp=32/32", rows_acc - r0, cols_acc - c0); end
   endtask

   task automatic test_backpressure();
      logic [63:0] rows [17];
      int acc;
      apply_reset();
      for (int i = 0; i < 17; i++) rows[i] = rnd64();
      acc = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         in_valid = (acc < 17);
         in_data = rows[(acc < 17) ? acc : 16];
         out_ready = (cyc >= 19);
         @(negedge clk);
         checks++; if (in_ready !== exp_ready()) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready()); end
         if (cyc >= 16 && cyc <= 26) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_held cyc=%0d got=%b exp=0", cyc, in_ready); end
         end
         if (cyc == 16) begin
            checks++; if (blk_cnt !== 2'd2) begin failures++; $display("FAIL bp_blk_cnt got=%0d exp=2", blk_cnt); end
         end
         if (cyc == 27) begin
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", in_ready); end
         end
         checks++; if (out_data !== exp_col()) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_col()); end
         checks++; if (blk_cnt !== exp_cnt()) begin failures++; $display("FAIL bp_cnt cyc=%0d got=%0d exp=%0d", cyc, blk_cnt, exp_cnt()); end
         if (in_valid && exp_ready()) begin
            if (acc == 16) begin
               checks++; if (cyc != 27) begin failures++; $display("FAIL bp_row17_cycle got=%0d exp=27", cyc); end
            end
            acc++;
         end
         advance();
      end
      checks++; if (acc != 17) begin failures++; $display("FAIL bp_rows got=%0d exp=17", acc); end
   endtask

   task automatic test_stall();
      logic [63:0] rows [8];
      logic [63:0] prev_data, w;
      logic prev_valid, prev_ready;
      int acc;
      apply_reset();
      for (int i = 0; i < 8; i++) rows[i] = rnd64();
      acc = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b1;
      prev_data = '0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         in_valid = (acc < 8);
         in_data = rows[(acc < 8) ? acc : 7];
         out_ready = (cyc % 2 == 0);
         @(negedge clk);
         if (prev_valid && !prev_ready) begin
            checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_data, prev_data); end
         end
         checks++; if (out_data !== exp_col()) begin failures++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_col()); end
         checks++; if (out_valid !== exp_valid()) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid()); end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data = out_data;
         if (in_valid && exp_ready()) acc++;
         advance();
      end
      checks++; if (acc_cols.size() != 8) begin failures++; $display("FAIL stall_col_count got=%0d exp=8", acc_cols.size()); end
      for (int j = 0; j < 8 && j < acc_cols.size(); j++) begin
         for (int r = 0; r < 8; r++) w[63-8*r -: 8] = rows[r][63-8*j -: 8];
         checks++; if (acc_cols[j] !== w) begin failures++; $display("FAIL stall_order col=%0d got=%h exp=%h", j, acc_cols[j], w); end
      end
   endtask

   task automatic test_reset_mid();
      int r;
      apply_reset();
      for (int cyc = 0; cyc < 13; cyc++) begin
         in_valid = 1'b1;
         in_data = rnd64();
         out_ready = 1'b1;
         @(negedge clk);
         checks++; if (out_data !== exp_col()) begin failures++; $display("FAIL rm_pre_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_col()); end
         advance();
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_draining got=%b exp=1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL rm_out_data got=%h exp=0", out_data); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
      checks++; if (blk_cnt !== 2'd0) begin failures++; $display("FAIL rm_blk_cnt got=%0d exp=0", blk_cnt); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      r = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid = (r < 8);
         in_data = (r < 8) ? pat_row(r) : '0;
         out_ready = 1'b1;
         @(negedge clk);
         checks++; if (out_valid !== exp_valid()) begin failures++; $display("FAIL rm_post_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid()); end
         if (exp_valid()) begin
            checks++; if (out_data !== pat_col(col_idx)) begin failures++; $display("FAIL rm_post_data cyc=%0d got=%h exp=%h", cyc, out_data, pat_col(col_idx)); end
         end
         if (in_valid && exp_ready()) r++;
         advance();
      end
      checks++; if (acc_cols.size() != 8) begin failures++; $display("FAIL rm_col_count got=%0d exp=8", acc_cols.size()); end
   endtask

   task automatic test_gaps();
      int r;
      apply_reset();
      r = 0;
      for (int cyc = 0; cyc < 100 && acc_cols.size() < 8; cyc++) begin
         in_valid = (r < 8) && ($urandom_range(0, 3) != 0) && (cyc % 4 != 0);
         in_data = in_valid ? pat_row(r) : rnd64();
         out_ready = 1'b1;
         @(negedge clk);
         checks++; if (out_valid !== exp_valid()) begin failures++; $display("FAIL gap_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid()); end
         if (exp_valid()) begin
            checks++; if (out_data !== pat_col(col_idx)) begin failures++; $display("FAIL gap_data cyc=%0d got=%h exp=%h", cyc, out_data, pat_col(col_idx)); end
         end
         if (in_valid && exp_ready()) r++;
         advance();
      end
      in_valid = 1'b0;
      checks++; if (acc_cols.size() != 8) begin failures++; $display("FAIL gap_col_count got=%0d exp=8", acc_cols.size()); end
   endtask

   initial begin
      test_reset();
      test_transpose();
      test_streaming();
      test_backpressure();
      test_stall();
      test_reset_mid();
      test_gaps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
